led_strip_scanner: RTL and testbench

Pixel-source stage feeding the palette in the LED counter display. Walks the ROM address across an 8-LED strip image in step with the timing generator's x/y/DE signals. Per pixel, selects the "LED on" or "LED off" ROM word from the corresponding bit of a frame-driven counter and emits the palette colour index. Outside the strip, it emits index 0.

---
 rtl/led_counter_pkg.sv | 16 +
 rtl/led_strip_scanner_frame_stepper.sv | 78 +++++++
 rtl/led_strip_scanner.sv | 130 +++++++++++++
 tb/tb_led_strip_scanner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_counter_pkg.sv
// Shared geometry, bus widths and the Gray helper for the LED counter display pixel path.
package led_counter_pkg;

    localparam int H_ACTIVE = 480;
    localparam int LED_W    = 60;
    localparam int NUM_LEDS = 8;
    localparam int STRIP_Y0 = 104;
    localparam int STRIP_H  = 64;
    localparam int ROM_AW   = 15;
    localparam int COLOR_W  = 16;

    function automatic logic [31:0] to_gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/led_strip_scanner_frame_stepper.sv
// Frame-rate counter: i_vde edge detect, frame divider, pause, step tick and tear-free shown value.
// Build option LED_COUNTER_GRAY_EN switches the displayed value to Gray code.
module frame_stepper import led_counter_pkg::*; #(
    parameter int CW        = led_counter_pkg::NUM_LEDS,
    parameter int FRAME_DIV = 30
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_vde,
    input  logic          i_pause,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_shown,
    output logic          o_tick
);

    logic          vde_q;
    logic          fall_s;
    logic          rise_s;
    logic [7:0]    fdiv_q, fdiv_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] disp_q, disp_d;
    logic [CW-1:0] shown_q, shown_d;
    logic          tick_q, tick_d;

    assign fall_s = vde_q & ~i_vde;
    assign rise_s = ~vde_q & i_vde;

    // Pause wins over a coincident frame event: the divider holds and no tick is issued.
    always_comb begin
        fdiv_d  = fdiv_q;
        count_d = count_q;
        tick_d  = 1'b0;
        if (fall_s && !i_pause) begin
            if (fdiv_q == 8'(FRAME_DIV - 1)) begin
                fdiv_d  = 8'd0;
                count_d = count_q + CW'(1'b1);
                tick_d  = 1'b1;
            end else begin
                fdiv_d  = fdiv_q + 8'd1;
            end
        end else begin
            fdiv_d = fdiv_q;
        end
`ifdef LED_COUNTER_GRAY_EN
        disp_d = CW'(to_gray(32'(count_d)));
`else
        disp_d = count_d;
`endif
        if (rise_s) begin
            shown_d = disp_q;
        end else begin
            shown_d = shown_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vde_q   <= 1'b0;
            fdiv_q  <= 8'd0;
            count_q <= CW'(1'b0);
            disp_q  <= CW'(1'b0);
            shown_q <= CW'(1'b0);
            tick_q  <= 1'b0;
        end else begin
            vde_q   <= i_vde;
            fdiv_q  <= fdiv_d;
            count_q <= count_d;
            disp_q  <= disp_d;
            shown_q <= shown_d;
            tick_q  <= tick_d;
        end
    end

    assign o_count = disp_q;
    assign o_shown = shown_q;
    assign o_tick  = tick_q;

endmodule

// File: rtl/led_strip_scanner.sv
// Pixel source for the LED strip: walks the ROM address and picks LED-on/off words per cell.
// Build option LED_COUNTER_GRAY_EN (in frame_stepper) selects a Gray-coded counter display.
module led_strip_scanner import led_counter_pkg::*; #(
    parameter int H_ACTIVE  = led_counter_pkg::H_ACTIVE,
    parameter int NUM_LEDS  = led_counter_pkg::NUM_LEDS,
    parameter int LED_W     = led_counter_pkg::LED_W,
    parameter int STRIP_Y0  = led_counter_pkg::STRIP_Y0,
    parameter int STRIP_H   = led_counter_pkg::STRIP_H,
    parameter int FRAME_DIV = 30,
    parameter int ROM_LAT   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [8:0]          i_x,
    input  logic [8:0]          i_y,
    input  logic                i_hde,
    input  logic                i_vde,
    input  logic                i_pause,
    input  logic [15:0]         i_rom_on,
    input  logic [15:0]         i_rom_off,
    output logic [14:0]         o_rom_addr,
    output logic [15:0]         o_color,
    output logic [NUM_LEDS-1:0] o_count,
    output logic                o_tick
);

    localparam int CW = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PD = ROM_LAT - 1;

    logic                active_s;
    logic                in_strip_s;
    logic                sel_s;
    logic [NUM_LEDS-1:0] shown_s;
    logic [ROM_AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]       col_q, col_d;
    logic [LW-1:0]       led_q, led_d;
    logic [PD-1:0]       strip_pipe_q;
    logic [PD-1:0]       sel_pipe_q;
    logic                sync_ok_q, sync_ok_d;
    logic [COLOR_W-1:0]  color_q, color_d;

    frame_stepper #(
        .CW        (NUM_LEDS),
        .FRAME_DIV (FRAME_DIV)
    ) u_stepper (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vde   (i_vde),
        .i_pause (i_pause),
        .o_count (o_count),
        .o_shown (shown_s),
        .o_tick  (o_tick)
    );

    assign active_s   = i_hde & i_vde;
    assign in_strip_s = active_s
                        && ({1'b0, i_x} < 10'(H_ACTIVE))
                        && (i_y >= 9'(STRIP_Y0))
                        && ({1'b0, i_y} < 10'(STRIP_Y0 + STRIP_H));
    assign sel_s      = shown_s[LW'(NUM_LEDS - 1) - led_q];

    always_comb begin
        if (!i_vde) begin
            addr_d = ROM_AW'(1'b0);
        end else if (in_strip_s) begin
            addr_d = addr_q + ROM_AW'(1'b1);
        end else begin
            addr_d = addr_q;
        end
    end

    // Line blanking clears the cell position even on the cycle the column would wrap.
    always_comb begin
        col_d = col_q;
        led_d = led_q;
        if (!i_hde) begin
            col_d = CW'(1'b0);
            led_d = LW'(1'b0);
        end else if (active_s) begin
            if (col_q == CW'(LED_W - 1)) begin
                col_d = CW'(1'b0);
                led_d = (led_q == LW'(NUM_LEDS - 1)) ? LW'(1'b0) : led_q + LW'(1'b1);
            end else begin
                col_d = col_q + CW'(1'b1);
            end
        end else begin
            col_d = col_q;
            led_d = led_q;
        end
    end

    always_comb begin
        sync_ok_d = sync_ok_q | ~i_vde;
        if (sync_ok_q && strip_pipe_q[PD-1]) begin
            color_d = sel_pipe_q[PD-1] ? i_rom_on : i_rom_off;
        end else begin
            color_d = 16'h0000;
        end
    end

    // The output register is the last alignment stage, so o_color lands ROM_LAT cycles after its address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q       <= ROM_AW'(1'b0);
            col_q        <= CW'(1'b0);
            led_q        <= LW'(1'b0);
            strip_pipe_q <= PD'(1'b0);
            sel_pipe_q   <= PD'(1'b0);
            sync_ok_q    <= 1'b0;
            color_q      <= 16'h0000;
        end else begin
            addr_q          <= addr_d;
            col_q           <= col_d;
            led_q           <= led_d;
            strip_pipe_q[0] <= in_strip_s;
            sel_pipe_q[0]   <= sel_s;
            for (int k = 1; k < PD; k++) begin
                strip_pipe_q[k] <= strip_pipe_q[k-1];
                sel_pipe_q[k]   <= sel_pipe_q[k-1];
            end
            sync_ok_q       <= sync_ok_d;
            color_q         <= color_d;
        end
    end

    assign o_rom_addr = addr_q;
    assign o_color    = color_q;

endmodule

// File: tb/tb_led_strip_scanner.sv
// Scoreboard bench for led_strip_scanner with FRAME_DIV=2 and ROM_LAT=2.
module tb_led_strip_scanner;

    localparam int FD = 2;
    localparam logic [15:0] ROM_ON  = 16'hA5C3;
    localparam logic [15:0] ROM_OFF = 16'h3C5A;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [8:0]  i_x, i_y;
    logic        i_hde, i_vde, i_pause;
    logic [15:0] i_rom_on, i_rom_off;
    logic [14:0] o_rom_addr;
    logic [15:0] o_color;
    logic [7:0]  o_count;
    logic        o_tick;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_fdiv, m_addr, exp_addr_v;
    logic [7:0]  m_count, m_shown;
    logic        m_sync, m_vde_prev, m_tick;
    logic [14:0] obs_addr;
    logic [15:0] exp_color_q[$];

    led_strip_scanner #(.FRAME_DIV(FD), .ROM_LAT(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y),
        .i_hde(i_hde), .i_vde(i_vde), .i_pause(i_pause),
        .i_rom_on(i_rom_on), .i_rom_off(i_rom_off),
        .o_rom_addr(o_rom_addr), .o_color(o_color),
        .o_count(o_count), .o_tick(o_tick)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] disp(input logic [7:0] c);
`ifdef LED_COUNTER_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    task automatic model_reset();
        m_fdiv = 0; m_addr = 0; m_count = 8'd0; m_shown = 8'd0;
        m_sync = 1'b0; m_vde_prev = 1'b0; m_tick = 1'b0;
        exp_color_q.delete();
    endtask

    // Drive one pixel cycle, queue its expected colour, clock it and advance the model.
    task automatic step(input int x, input int y, input logic hde, input logic vde, input logic pse);
        logic strip;
        int led;
        logic [15:0] e;
        i_x = 9'(x); i_y = 9'(y); i_hde = hde; i_vde = vde; i_pause = pse;
        strip = hde && vde && (y >= 104) && (y < 168) && (x < 480);
        led = x / 60;
        if (led > 7) led = 7;
        e = (m_sync && strip) ? (m_shown[7 - led] ? ROM_ON : ROM_OFF) : 16'h0000;
        while (exp_color_q.size() > 1) void'(exp_color_q.pop_front());
        exp_color_q.push_back(e);
        #1;
        obs_addr = o_rom_addr;
        exp_addr_v = m_addr;
        @(posedge i_clk);
        #1;
        m_tick = 1'b0;
        if (!vde) m_addr = 0;
        else if (strip) m_addr = m_addr + 1;
        if (m_vde_prev && !vde && !pse) begin
            if (m_fdiv == FD - 1) begin
                m_fdiv = 0; m_count = m_count + 8'd1; m_tick = 1'b1;
            end else begin
                m_fdiv = m_fdiv + 1;
            end
        end
        if (!m_vde_prev && vde) m_shown = disp(m_count);
        if (!vde) m_sync = 1'b1;
        m_vde_prev = vde;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_x = 9'd0; i_y = 9'd0; i_hde = 1'b0; i_vde = 1'b0;
        i_pause = 1'b0; i_rom_on = ROM_ON; i_rom_off = ROM_OFF;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_rom_addr !== 15'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", o_rom_addr); end
        checks++; if (o_color !== 16'h0000) begin failures++; $display("FAIL reset_color got=%h exp=0000", o_color); end
        checks++; if (o_count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", o_count); end
        checks++; if (o_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", o_tick); end
        i_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_counter_steps();
        for (int f = 0; f < 258; f++) begin
            for (int c = 0; c < 4; c++) begin
                step(0, 0, 1'b0, (c < 2), 1'b0);
                checks++; if (o_tick !== m_tick) begin failures++; $display("FAIL step_tick got=%b exp=%b", o_tick, m_tick); end
                checks++; if (o_count !== disp(m_count)) begin failures++; $display("FAIL step_count got=%h exp=%h", o_count, disp(m_count)); end
                if (m_tick && m_count == 8'd8) begin
`ifdef LED_COUNTER_GRAY_EN
                    checks++; if (o_count !== 8'h0C || $countones(o_count ^ 8'h04) != 1) begin failures++; $display("FAIL gray_7_to_8 got=%h exp=0c", o_count); end
`else
                    checks++; if (o_count !== 8'h08) begin failures++; $display("FAIL bin_7_to_8 got=%h exp=08", o_count); end
`endif
                end
            end
        end
        checks++; if (o_count !== disp(8'h81)) begin failures++; $display("FAIL count_81 got=%h exp=%h", o_count, disp(8'h81)); end
    endtask

    task automatic test_strip_colors();
        logic [15:0] e;
        for (int y = 103; y <= 168; y++) begin
            for (int x = 0; x < 488; x++) begin
                step((x < 480) ? x : 0, y, (x < 480), 1'b1, 1'b0);
                checks++; if (obs_addr !== 15'(exp_addr_v)) begin failures++; $display("FAIL sweep_addr y=%0d x=%0d got=%0d exp=%0d", y, x, obs_addr, exp_addr_v); end
                if (y == 167 && x == 479) begin
                    checks++; if (obs_addr !== 15'd30719) begin failures++; $display("FAIL last_addr got=%0d exp=30719", obs_addr); end
                end
                if (exp_color_q.size() == 2) begin
                    e = exp_color_q.pop_front();
                    checks++; if (o_color !== e) begin failures++; $display("FAIL strip_color y=%0d x=%0d got=%h exp=%h", y, x, o_color, e); end
                end
            end
        end
        step(0, 0, 1'b0, 1'b1, 1'b0);
        checks++; if (obs_addr !== 15'd30720) begin failures++; $display("FAIL hold_addr got=%0d exp=30720", obs_addr); end
        step(0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_addr !== 15'd0) begin failures++; $display("FAIL addr_after_fall got=%0d exp=0", obs_addr); end
    endtask

    task automatic test_wrap();
        bit wrapped = 1'b0;
        for (int f = 0; f < 600 && !wrapped; f++) begin
            for (int c = 0; c < 4; c++) begin
                step(0, 0, 1'b0, (c < 2), 1'b0);
                checks++; if (o_tick !== m_tick) begin failures++; $display("FAIL wrap_tick got=%b exp=%b", o_tick, m_tick); end
                if (m_tick && m_count == 8'd0) begin
                    wrapped = 1'b1;
                    checks++; if (o_count !== 8'h00 || o_tick !== 1'b1) begin failures++; $display("FAIL wrap_zero count=%h tick=%b exp=00/1", o_count, o_tick); end
                end
            end
        end
        if (!wrapped) begin
            checks++; failures++; $display("FAIL wrap_timeout count=%h exp=wrap to 00", o_count);
        end
    endtask

    task automatic test_pause();
        logic [7:0] held;
        int held_fdiv, events;
        bit ticked = 1'b0;
        held = disp(m_count);
        held_fdiv = m_fdiv;
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 4; c++) begin
                step(0, 0, 1'b0, (c < 2), 1'b1);
                checks++; if (o_tick !== 1'b0) begin failures++; $display("FAIL pause_tick got=%b exp=0", o_tick); end
            end
        end
        checks++; if (o_count !== held) begin failures++; $display("FAIL pause_count got=%h exp=%h", o_count, held); end
        events = 0;
        for (int f = 0; f < 10 && !ticked; f++) begin
            for (int c = 0; c < 4; c++) begin
                step(0, 0, 1'b0, (c < 2), 1'b0);
                if (c == 2) events++;
                if (o_tick === 1'b1) ticked = 1'b1;
            end
        end
        checks++; if (!ticked || events != FD - held_fdiv) begin failures++; $display("FAIL pause_resume events=%0d exp=%0d", events, FD - held_fdiv); end
        checks++; if (o_count !== disp(held + 8'd1)) begin failures++; $display("FAIL resume_count got=%h exp=%h", o_count, disp(held + 8'd1)); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] e;
        step(0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        for (int x = 0; x < 200; x++) begin
            step(x, 120, 1'b1, 1'b1, 1'b0);
            if (exp_color_q.size() == 2) begin
                e = exp_color_q.pop_front();
                checks++; if (o_color !== e) begin failures++; $display("FAIL pre_reset_color x=%0d got=%h exp=%h", x, o_color, e); end
            end
        end
        i_x = 9'd200;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_rom_addr !== 15'd0) begin failures++; $display("FAIL midreset_addr got=%0d exp=0", o_rom_addr); end
        checks++; if (o_color !== 16'h0000) begin failures++; $display("FAIL midreset_color got=%h exp=0000", o_color); end
        checks++; if (o_count !== 8'h00) begin failures++; $display("FAIL midreset_count got=%h exp=00", o_count); end
        checks++; if (o_tick !== 1'b0) begin failures++; $display("FAIL midreset_tick got=%b exp=0", o_tick); end
        model_reset();
        #2;
        i_rst_n = 1'b1;
        for (int y = 120; y <= 121; y++) begin
            for (int x = (y == 120) ? 201 : 0; x < 488; x++) begin
                step((x < 480) ? x : 0, y, (x < 480), 1'b1, 1'b0);
                if (exp_color_q.size() == 2) begin
                    e = exp_color_q.pop_front();
                    checks++; if (o_color !== e) begin failures++; $display("FAIL resync_zero y=%0d x=%0d got=%h exp=%h", y, x, o_color, e); end
                end
            end
        end
        step(0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        for (int y = 104; y <= 105; y++) begin
            for (int x = 0; x < 488; x++) begin
                step((x < 480) ? x : 0, y, (x < 480), 1'b1, 1'b0);
                if (exp_color_q.size() == 2) begin
                    e = exp_color_q.pop_front();
                    checks++; if (o_color !== e) begin failures++; $display("FAIL resumed_color y=%0d x=%0d got=%h exp=%h", y, x, o_color, e); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_counter_steps();
        test_strip_colors();
        test_wrap();
        test_pause();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
